// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Writeback arbiter between the execution pipes (0 ALU, 1 LSU, 2 MUL, 3 DIV)
// and the single register-file write port. One pipe is granted per cycle by
// fixed priority (lowest ID wins). A per-pipe wait counter promotes pipes that
// have been denied for STARVE_LIMIT consecutive cycles ahead of fixed priority.
// The granted beat is registered and presented on wb_* for exactly one cycle.
//
// Ports:
//   clk          core clock
//   rst          synchronous active-high reset
//   req_valid    per-pipe result valid
//   req_wr_en    per-pipe register-write flag
//   req_rd       per-pipe destination, pipe i at [i*REG_WIDTH +: REG_WIDTH]
//   req_data     per-pipe result, pipe i at [i*32 +: 32]
//   req_ready    one-hot (or zero) grant, combinational
//   wb_valid     registered: a beat was accepted last cycle
//   wb_wr_en     registered regfile write enable (suppressed for x0)
//   wb_rd        registered destination register
//   wb_wr_data   registered write data
//   wb_pipe_id   registered ID of the granted pipe
// -----------------------------------------------------------------------------
module wb_arbiter #(
   parameter int NUM_PIPES    = 4,
   parameter int REG_WIDTH    = 5,
   parameter int STARVE_LIMIT = 8,
   parameter int CNT_WIDTH    = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_PIPES-1:0]           req_valid,
   input  logic [NUM_PIPES-1:0]           req_wr_en,
   input  logic [NUM_PIPES*REG_WIDTH-1:0] req_rd,
   input  logic [NUM_PIPES*32-1:0]        req_data,
   output logic [NUM_PIPES-1:0]           req_ready,
   output logic                           wb_valid,
   output logic                           wb_wr_en,
   output logic [REG_WIDTH-1:0]           wb_rd,
   output logic [31:0]                    wb_wr_data,
   output logic [1:0]                     wb_pipe_id
);

   localparam logic [CNT_WIDTH-1:0] LIMIT_C = CNT_WIDTH'(STARVE_LIMIT);
   localparam logic                 PROMO_EN = (STARVE_LIMIT != 0);

   logic [CNT_WIDTH-1:0] wait_cnt_q [NUM_PIPES];
   logic [CNT_WIDTH-1:0] wait_cnt_d [NUM_PIPES];

   logic [NUM_PIPES-1:0] starve_s;
   logic [NUM_PIPES-1:0] grant_vec_s;
   logic [1:0]           grant_idx_s;
   logic                 grant_any_s;
   logic [REG_WIDTH-1:0] win_rd_s;
   logic [31:0]          win_data_s;
   logic                 win_wr_en_s;

   logic                 wb_valid_q,   wb_valid_d;
   logic                 wb_wr_en_q,   wb_wr_en_d;
   logic [REG_WIDTH-1:0] wb_rd_q,      wb_rd_d;
   logic [31:0]          wb_wr_data_q, wb_wr_data_d;
   logic [1:0]           wb_pipe_id_q, wb_pipe_id_d;

   // Grant selection: starving requesters first, then plain fixed priority.
   always_comb begin
      starve_s    = '0;
      grant_vec_s = '0;
      grant_idx_s = 2'd0;
      grant_any_s = 1'b0;
      for (int i = 0; i < NUM_PIPES; i++) begin
         starve_s[i] = PROMO_EN && req_valid[i] && (wait_cnt_q[i] >= LIMIT_C);
      end
      // Scan high-to-low so the lowest matching ID is the one left standing.
      if (|starve_s) begin
         for (int i = NUM_PIPES - 1; i >= 0; i--) begin
            if (starve_s[i]) begin
               grant_idx_s = 2'(i);
            end else begin
               grant_idx_s = grant_idx_s;
            end
         end
         grant_any_s = !rst;
      end else if (|req_valid) begin
         for (int i = NUM_PIPES - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
               grant_idx_s = 2'(i);
            end else begin
               grant_idx_s = grant_idx_s;
            end
         end
         grant_any_s = !rst;
      end else begin
         grant_any_s = 1'b0;
      end
      if (grant_any_s) begin
         grant_vec_s[grant_idx_s] = 1'b1;
      end else begin
         grant_vec_s = '0;
      end
   end

   assign req_ready = grant_vec_s;

   // Winner payload mux.
   always_comb begin
      win_rd_s    = req_rd[int'(grant_idx_s)*REG_WIDTH +: REG_WIDTH];
      win_data_s  = req_data[int'(grant_idx_s)*32 +: 32];
      // A write to x0 is consumed but never reaches the register file.
      win_wr_en_s = req_wr_en[grant_idx_s] && (win_rd_s != {REG_WIDTH{1'b0}});
   end

   // Next state for the output beat register and the wait counters.
   always_comb begin
      if (grant_any_s) begin
         wb_valid_d   = 1'b1;
         wb_wr_en_d   = win_wr_en_s;
         wb_rd_d      = win_rd_s;
         wb_wr_data_d = win_data_s;
         wb_pipe_id_d = grant_idx_s;
      end else begin
         wb_valid_d   = 1'b0;
         wb_wr_en_d   = 1'b0;
         wb_rd_d      = wb_rd_q;
         wb_wr_data_d = wb_wr_data_q;
         wb_pipe_id_d = wb_pipe_id_q;
      end
      for (int i = 0; i < NUM_PIPES; i++) begin
         if (grant_vec_s[i] || !req_valid[i]) begin
            wait_cnt_d[i] = '0;
         end else if (wait_cnt_q[i] != {CNT_WIDTH{1'b1}}) begin
            wait_cnt_d[i] = wait_cnt_q[i] + CNT_WIDTH'(1);
         end else begin
            wait_cnt_d[i] = wait_cnt_q[i];
         end
      end
   end

   // State registers with synchronous reset; reset drops any beat in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid_q   <= 1'b0;
         wb_wr_en_q   <= 1'b0;
         wb_rd_q      <= '0;
         wb_wr_data_q <= 32'd0;
         wb_pipe_id_q <= 2'd0;
         for (int i = 0; i < NUM_PIPES; i++) begin
            wait_cnt_q[i] <= '0;
         end
      end else begin
         wb_valid_q   <= wb_valid_d;
         wb_wr_en_q   <= wb_wr_en_d;
         wb_rd_q      <= wb_rd_d;
         wb_wr_data_q <= wb_wr_data_d;
         wb_pipe_id_q <= wb_pipe_id_d;
         for (int i = 0; i < NUM_PIPES; i++) begin
            wait_cnt_q[i] <= wait_cnt_d[i];
         end
      end
   end

   assign wb_valid   = wb_valid_q;
   assign wb_wr_en   = wb_wr_en_q;
   assign wb_rd      = wb_rd_q;
   assign wb_wr_data = wb_wr_data_q;
   assign wb_pipe_id = wb_pipe_id_q;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_wr_en;
   logic [19:0] req_rd;
   logic [127:0] req_data;
   logic [3:0]  req_ready;
   logic        wb_valid;
   logic        wb_wr_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_wr_data;
   logic [1:0]  wb_pipe_id;

   typedef struct packed {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [1:0]  id;
   } beat_t;

   beat_t q[$];
   beat_t last;
   int    total = 0;
   int    bad   = 0;

   always #5 clk = ~clk;

   wb_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_wr_en  (req_wr_en),
      .req_rd     (req_rd),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .wb_valid   (wb_valid),
      .wb_wr_en   (wb_wr_en),
      .wb_rd      (wb_rd),
      .wb_wr_data (wb_wr_data),
      .wb_pipe_id (wb_pipe_id)
   );

   task automatic set_pipe(input int p, input logic v, input logic we,
                           input logic [4:0] rd, input logic [31:0] d);
      req_valid[p]        = v;
      req_wr_en[p]        = we;
      req_rd[p*5 +: 5]    = rd;
      req_data[p*32 +: 32] = d;
   endtask

   // One clock: check ready mid-cycle, push expected beat, check wb after edge.
   task automatic tick(input logic [3:0] exp_ready, input string name);
      beat_t b;
      beat_t got;
      int    g;
      #3;
      total++;
      if (req_ready !== exp_ready) begin
         bad++;
         $display("FAIL %s ready: got %b want %b", name, req_ready, exp_ready);
      end
      if (exp_ready != 4'b0000 && !rst) begin
         g = 0;
         for (int i = 0; i < 4; i++) if (exp_ready[i]) g = i;
         b.rd   = req_rd[g*5 +: 5];
         b.data = req_data[g*32 +: 32];
         b.we   = req_wr_en[g] && (b.rd != 5'd0);
         b.id   = 2'(g);
         q.push_back(b);
      end
      @(posedge clk);
      #1;
      if (rst) begin
         q.delete();
         last = '0;
      end
      got = {wb_wr_en, wb_rd, wb_wr_data, wb_pipe_id};
      total++;
      if (q.size() > 0) begin
         b = q.pop_front();
         if ({wb_valid, got} !== {1'b1, b}) begin
            bad++;
            $display("FAIL %s beat: got v=%b we=%b rd=%0d data=%h id=%0d want v=1 we=%b rd=%0d data=%h id=%0d",
                     name, wb_valid, wb_wr_en, wb_rd, wb_wr_data, wb_pipe_id, b.we, b.rd, b.data, b.id);
         end
         last = b;
      end else begin
         b = last;
         b.we = 1'b0;
         if ({wb_valid, got} !== {1'b0, b}) begin
            bad++;
            $display("FAIL %s idle: got v=%b we=%b rd=%0d data=%h id=%0d want v=0 we=0 rd=%0d data=%h id=%0d",
                     name, wb_valid, wb_wr_en, wb_rd, wb_wr_data, wb_pipe_id, b.rd, b.data, b.id);
         end
      end
   endtask

   task automatic clear_all();
      req_valid = 4'b0000;
      req_wr_en = 4'b0000;
      req_rd    = 20'd0;
      req_data  = 128'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int p = 0; p < 4; p++) set_pipe(p, 1'b1, 1'b1, 5'(p + 1), 32'h1000_0000 + 32'(p));
      tick(4'b0000, "reset0");
      tick(4'b0000, "reset1");
      rst = 1'b0;
      clear_all();
      tick(4'b0000, "reset_idle");
   endtask

   task automatic test_single();
      set_pipe(2, 1'b1, 1'b1, 5'd7, 32'hDEADBEEF);
      tick(4'b0100, "single_mul");
      clear_all();
      tick(4'b0000, "single_hold");
   endtask

   task automatic test_fixed_priority();
      set_pipe(0, 1'b1, 1'b1, 5'd1, 32'hA0A0_0001);
      set_pipe(1, 1'b1, 1'b1, 5'd2, 32'hB0B0_0002);
      set_pipe(3, 1'b1, 1'b1, 5'd3, 32'hD0D0_0003);
      tick(4'b0001, "prio_alu");
      req_valid[0] = 1'b0;
      tick(4'b0010, "prio_lsu");
      req_valid[1] = 1'b0;
      tick(4'b1000, "prio_div");
      clear_all();
      tick(4'b0000, "prio_idle");
   endtask

   task automatic test_all_four();
      for (int p = 0; p < 4; p++) set_pipe(p, 1'b1, 1'b1, 5'(p + 10), $urandom);
      for (int p = 0; p < 4; p++) begin
         tick(4'b0001 << p, "all_four");
         req_valid[p] = 1'b0;
      end
      clear_all();
      tick(4'b0000, "all_four_idle");
   endtask

   task automatic test_starvation();
      set_pipe(3, 1'b1, 1'b1, 5'd9, 32'hD1D1_D1D1);
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 8; k++) begin
            set_pipe(0, 1'b1, 1'b1, 5'(k + 1), $urandom);
            tick(4'b0001, "starve_deny");
         end
         set_pipe(0, 1'b1, 1'b1, 5'd4, $urandom);
         tick(4'b1000, "starve_grant");
      end
      req_valid[3] = 1'b0;
      tick(4'b0001, "starve_after");
      clear_all();
      tick(4'b0000, "starve_idle");
   endtask

   task automatic test_dual_starve();
      set_pipe(2, 1'b1, 1'b1, 5'd12, 32'h2222_2222);
      set_pipe(3, 1'b1, 1'b1, 5'd13, 32'h3333_3333);
      for (int k = 0; k < 8; k++) begin
         set_pipe(0, 1'b1, 1'b1, 5'd1, $urandom);
         tick(4'b0001, "dual_deny");
      end
      tick(4'b0100, "dual_mul");
      req_valid[2] = 1'b0;
      tick(4'b1000, "dual_div");
      req_valid[3] = 1'b0;
      tick(4'b0001, "dual_alu");
      clear_all();
      tick(4'b0000, "dual_idle");
   endtask

   task automatic test_x0_nowrite();
      set_pipe(1, 1'b1, 1'b1, 5'd0, 32'h0BAD_0000);
      tick(4'b0010, "x0_lsu");
      clear_all();
      set_pipe(0, 1'b1, 1'b0, 5'd5, 32'h5555_AAAA);
      tick(4'b0001, "nowrite_alu");
      clear_all();
      tick(4'b0000, "nowrite_idle");
   endtask

   task automatic test_reset_mid();
      set_pipe(2, 1'b1, 1'b1, 5'd7, 32'hCAFE_F00D);
      tick(4'b0100, "mid_mul");
      clear_all();
      rst = 1'b1;
      tick(4'b0000, "mid_rst");
      rst = 1'b0;
      // Build up DIV's wait count, then reset with requests still held.
      set_pipe(0, 1'b1, 1'b1, 5'd1, 32'h1);
      set_pipe(3, 1'b1, 1'b1, 5'd3, 32'h3);
      for (int k = 0; k < 5; k++) tick(4'b0001, "mid_build");
      rst = 1'b1;
      tick(4'b0000, "mid_rst2");
      rst = 1'b0;
      for (int k = 0; k < 8; k++) tick(4'b0001, "mid_cnt_clear");
      tick(4'b1000, "mid_div");
      clear_all();
      tick(4'b0000, "mid_idle");
   endtask

   initial begin
      last = '0;
      clear_all();
      rst = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_fixed_priority();
      test_all_four();
      test_starvation();
      test_dual_starve();
      test_x0_nowrite();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
